// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and parity helper
// for the parametrised UART transceiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Data is zero-extended to 9 bits, so unused bits do not disturb the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through FIFO with extra-bit pointers;
// reports pushes that are dropped because the FIFO is full.
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             drop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_en
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A same-cycle pop frees the slot that a push into a full FIFO needs.
    assign pop      = rd_en & ~empty;
    assign push     = wr_en & (~full | pop);
    assign drop     = wr_en & ~push;
    assign rd_valid = ~empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; the wrap bit tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_trx_param.sv
// Parametrised full-duplex UART: TX FSM, RX FSM with
// synchronised input, and an RX FIFO carrying error flags.
module uart_trx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              txd,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    input  logic              err_clr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W + 1);
    localparam int FW = DATA_W + 2;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam bit            HAS_PAR   = (PARITY != PARITY_NONE);

    // ---------------- transmitter ----------------
    tx_state_t         tx_state, tx_state_n;
    logic [CW-1:0]     tx_cnt, tx_cnt_n;
    logic [IW-1:0]     tx_idx, tx_idx_n;
    logic [DATA_W-1:0] tx_shift, tx_shift_n;
    logic              tx_par, tx_par_n;
    logic              tx_tick;

    assign tx_tick = (tx_cnt == BIT_LAST);

    // TX state, bit timer, bit index and latched word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
        end
    end

    // TX next state and line level; word is latched on acceptance.
    always_comb begin
        tx_state_n = tx_state;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_ready   = 1'b0;
        txd        = 1'b1;
        unique case (tx_state)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    tx_state_n = TX_START;
                    tx_shift_n = tx_data;
                    tx_par_n   = parity_bit(9'(tx_data), PARITY);
                end
            end
            TX_START: begin
                txd = 1'b0;
                if (tx_tick) tx_state_n = TX_DATA;
            end
            TX_DATA: begin
                txd = tx_shift[0];
                if (tx_tick) begin
                    tx_shift_n = tx_shift >> 1;
                    if (tx_idx == DATA_LAST)
                        tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
                    else
                        tx_idx_n = tx_idx + IW'(1);
                end
            end
            TX_PARITY: begin
                txd = tx_par;
                if (tx_tick) tx_state_n = TX_STOP;
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_idx == STOP_LAST) tx_state_n = TX_IDLE;
                    else                     tx_idx_n = tx_idx + IW'(1);
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
        if (tx_state_n != tx_state || tx_state == TX_IDLE) begin
            tx_cnt_n = '0;
            tx_idx_n = '0;
        end else begin
            tx_cnt_n = tx_tick ? '0 : tx_cnt + CW'(1);
        end
    end

    // ---------------- receiver ----------------
    rx_state_t         rx_state, rx_state_n;
    logic [CW-1:0]     rx_cnt, rx_cnt_n;
    logic [IW-1:0]     rx_idx, rx_idx_n;
    logic [DATA_W-1:0] rx_shift, rx_shift_n;
    logic              rx_par, rx_par_n;
    logic              rx_s1, rx_s2, rx_prev;
    logic              rx_fall;
    logic              rx_tick;
    logic              push;
    logic              drop;
    logic              par_err;
    logic [FW-1:0]     push_word;
    logic [FW-1:0]     head;

    assign rx_fall = rx_prev & ~rx_s2;
    assign rx_tick = (rx_cnt == BIT_LAST);

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX state, bit timer, bit index and assembled frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_par   <= rx_par_n;
        end
    end

    // RX next state; samples at mid-bit, push on the first stop bit.
    always_comb begin
        rx_state_n = rx_state;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_par_n   = rx_par;
        push       = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (rx_fall) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST)
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_n = {rx_s2, rx_shift[DATA_W-1:1]};
                    if (rx_idx == DATA_LAST)
                        rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
                    else
                        rx_idx_n = rx_idx + IW'(1);
                end
            end
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_par_n   = rx_s2;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick) begin
                    push       = 1'b1;
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
        if (rx_state_n != rx_state || rx_state == RX_IDLE) begin
            rx_cnt_n = '0;
            rx_idx_n = '0;
        end else begin
            rx_cnt_n = rx_tick ? '0 : rx_cnt + CW'(1);
        end
    end

    assign par_err   = HAS_PAR &&
                       (rx_par != parity_bit(9'(rx_shift), PARITY));
    assign push_word = {rx_shift, par_err, ~rx_s2};

    uart_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (push_word),
        .wr_en    (push),
        .drop     (drop),
        .rd_data  (head),
        .rd_valid (rx_valid),
        .rd_en    (rx_ready)
    );

    assign rx_data       = head[FW-1:2];
    assign rx_parity_err = head[1];
    assign rx_frame_err  = head[0];

    // Sticky overrun; a new drop beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rx_overrun <= 1'b0;
        else if (drop)    rx_overrun <= 1'b1;
        else if (err_clr) rx_overrun <= 1'b0;
    end

endmodule
